// File: rtl/ram_bus_controller_pkg.sv
// Shared constants for the RAM bus controller: width defaults, MMIO register
// offsets and the controller state encoding.
package ram_bus_controller_pkg;

    localparam int ADDR_W_DEF    = 12;
    localparam int DATA_W_DEF    = 16;
    localparam int MMIO_BASE_DEF = 110;

    localparam logic [2:0] MMIO_TUBE   = 3'd0;
    localparam logic [2:0] MMIO_BTNS   = 3'd1;
    localparam logic [2:0] MMIO_IR_HI  = 3'd2;
    localparam logic [2:0] MMIO_IR_LO  = 3'd3;
    localparam logic [2:0] MMIO_IR_NEW = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_READ_WAIT = 2'd1,
        ST_CLEAR     = 2'd2
    } state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Address sequencer for the RAM clear sweep: counts 0..2^ADDR_W-1 and flags
// the final address so the controller can leave the clear state.
module ram_clear_seq #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] cnt_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // Next count: restart on start, step while sweeping, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = en_i && (cnt_q == '1);

endmodule

// File: rtl/ram_bus_controller.sv
// CPU-to-RAM bus controller with a small MMIO window (tube, buttons, IR) and a
// full-RAM clear sweep. Define IR_CAPTURE_EN to enable the IR capture registers.
module ram_bus_controller
    import ram_bus_controller_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic              clk,
    input  logic              res,
    input  logic              cpu_sel,
    input  logic              cpu_load,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              cpu_clr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    input  logic [3:0]        btns,
    input  logic [31:0]       ir_code,
    input  logic              ir_valid,
    output logic [DATA_W-1:0] tube_value
);

    localparam logic [ADDR_W:0] MMIO_LO = (ADDR_W+1)'(MMIO_BASE);
    localparam logic [ADDR_W:0] MMIO_HI = (ADDR_W+1)'(MMIO_BASE + 4);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] tube_q, tube_d;
    logic              clr_start_s;
    logic              clr_en_s;
    logic              clr_last_s;
    logic [ADDR_W-1:0] clr_cnt_s;
    logic              we_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;
    logic              mmio_hit_s;
    logic [2:0]        mmio_off_s;
    logic              ir_rd_new_s;
    logic [15:0]       ir_hi_s;
    logic [15:0]       ir_lo_s;
    logic              ir_new_s;

    assign mmio_hit_s = ({1'b0, cpu_addr} >= MMIO_LO) && ({1'b0, cpu_addr} <= MMIO_HI);
    assign mmio_off_s = 3'(cpu_addr - MMIO_LO[ADDR_W-1:0]);
    assign clr_en_s   = (state_q == ST_CLEAR);

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .res     (res),
        .start_i (clr_start_s),
        .en_i    (clr_en_s),
        .cnt_o   (clr_cnt_s),
        .last_o  (clr_last_s)
    );

    // Next state, RAM port drive and register updates; a clear request in IDLE
    // takes priority over any access presented in the same cycle.
    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        tube_d      = tube_q;
        clr_start_s = 1'b0;
        we_s        = 1'b0;
        addr_s      = cpu_addr;
        wdata_s     = cpu_wdata;
        ir_rd_new_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_clr) begin
                    state_d     = ST_CLEAR;
                    clr_start_s = 1'b1;
                end else if (cpu_sel) begin
                    if (mmio_hit_s) begin
                        if (cpu_load) begin
                            case (mmio_off_s)
                                MMIO_TUBE:   rdata_d = tube_q;
                                MMIO_BTNS:   rdata_d = DATA_W'(btns);
                                MMIO_IR_HI:  rdata_d = DATA_W'(ir_hi_s);
                                MMIO_IR_LO:  rdata_d = DATA_W'(ir_lo_s);
                                MMIO_IR_NEW: begin
                                    rdata_d     = DATA_W'(ir_new_s);
                                    ir_rd_new_s = 1'b1;
                                end
                                default:     rdata_d = rdata_q;
                            endcase
                        end else if (mmio_off_s == MMIO_TUBE) begin
                            tube_d = cpu_wdata;
                        end else begin
                            tube_d = tube_q;
                        end
                    end else if (cpu_load) begin
                        state_d = ST_READ_WAIT;
                    end else begin
                        we_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ_WAIT: begin
                rdata_d = ram_q;
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                addr_s  = clr_cnt_s;
                wdata_s = '0;
                we_s    = 1'b1;
                if (clr_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and CPU-visible registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            tube_q  <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            tube_q  <= tube_d;
        end
    end

`ifdef IR_CAPTURE_EN
    logic        ir_valid_q;
    logic [15:0] ir_hi_q, ir_hi_d;
    logic [15:0] ir_lo_q, ir_lo_d;
    logic        ir_new_q, ir_new_d;
    logic        ir_rise_s;

    assign ir_rise_s = ir_valid && !ir_valid_q;

    // Latch the code on an ir_valid rising edge; a new code beats a same-cycle read-clear.
    always_comb begin
        ir_hi_d  = ir_hi_q;
        ir_lo_d  = ir_lo_q;
        ir_new_d = ir_new_q;
        if (ir_rise_s) begin
            ir_hi_d  = ir_code[31:16];
            ir_lo_d  = ir_code[15:0];
            ir_new_d = 1'b1;
        end else if (ir_rd_new_s) begin
            ir_new_d = 1'b0;
        end else begin
            ir_new_d = ir_new_q;
        end
    end

    // IR capture registers.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ir_valid_q <= 1'b0;
            ir_hi_q    <= 16'h0000;
            ir_lo_q    <= 16'h0000;
            ir_new_q   <= 1'b0;
        end else begin
            ir_valid_q <= ir_valid;
            ir_hi_q    <= ir_hi_d;
            ir_lo_q    <= ir_lo_d;
            ir_new_q   <= ir_new_d;
        end
    end

    assign ir_hi_s  = ir_hi_q;
    assign ir_lo_s  = ir_lo_q;
    assign ir_new_s = ir_new_q;
`else
    logic unused_ir_s;

    assign unused_ir_s = ^{ir_code, ir_valid, ir_rd_new_s};
    assign ir_hi_s     = 16'h0000;
    assign ir_lo_s     = 16'h0000;
    assign ir_new_s    = 1'b0;
`endif

    // The write strobe is gated by reset so nothing reaches the RAM while res is low.
    assign ram_we     = we_s && res;
    assign ram_addr   = addr_s;
    assign ram_wdata  = wdata_s;
    assign cpu_stall  = (state_q != ST_IDLE);
    assign cpu_rdata  = rdata_q;
    assign tube_value = tube_q;

endmodule

// File: doc/ram_bus_controller.md
RAM_BUS_CONTROLLER -- requirements
Module: ram_bus_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM/bus address width.
REQ-002 SHALL have parameter DATA_W, default 16, RAM/bus data width.
REQ-003 SHALL have parameter MMIO_BASE, default 110, first memory-mapped I/O address; MMIO window is MMIO_BASE..MMIO_BASE+4.
REQ-004 SHALL have port: clk  in  1  the single clock for all logic.
REQ-005 SHALL have port: res  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: cpu_sel in 1 (bus request), cpu_load in 1 (1=read, 0=write), cpu_addr in ADDR_W, cpu_wdata in DATA_W.
REQ-007 SHALL have ports: cpu_rdata out DATA_W (read data), cpu_stall out 1 (CPU must hold request), cpu_clr in 1 (RAM-clear request pulse).
REQ-008 SHALL have ports: ram_addr out ADDR_W, ram_wdata out DATA_W, ram_we out 1, ram_q in DATA_W (synchronous-read RAM port, 1-cycle latency).
REQ-009 SHALL have ports: btns in 4, ir_code in 32, ir_valid in 1 (clk-domain), tube_value out DATA_W.

Function
REQ-010 FSM states: IDLE, READ_WAIT, CLEAR; request sampled only in IDLE.
REQ-011 IDLE, cpu_clr=1: enter CLEAR, counter=0; any concurrent cpu_sel access dropped (clear wins).
REQ-012 CLEAR: ram_addr=counter, ram_wdata=0, ram_we=1 each cycle; counter 0..2^ADDR_W-1 (4096 cycles); after last address return to IDLE; cpu_clr ignored while in CLEAR.
REQ-013 cpu_stall=1 in every CLEAR and READ_WAIT cycle, else 0.
REQ-014 IDLE RAM write (addr outside MMIO window, cpu_load=0): ram_we=1, ram_addr=cpu_addr, ram_wdata=cpu_wdata same cycle; no stall.
REQ-015 IDLE RAM read: ram_addr=cpu_addr, go READ_WAIT; at end of READ_WAIT cpu_rdata<=ram_q, return IDLE; total 2 cycles.
REQ-016 MMIO reads complete in 1 cycle, no stall, cpu_rdata registered: +0 tube_value, +1 {12'h0,btns}, +2 ir_code[31:16], +3 ir_code[15:0] latched copy, +4 {15'h0,ir_new}.
REQ-017 MMIO write to +0 updates tube_value next edge; writes to +1..+4 ignored; ram_we=0 for all MMIO accesses.
REQ-018 cpu_rdata holds last value when no read completes.

Reset
REQ-019 res low: state IDLE, counter 0, cpu_rdata 0, tube_value 0, IR latches 0, ir_new 0; cpu_stall 0 and ram_we 0 while in reset.
REQ-020 Reset mid-CLEAR aborts clear immediately; partially cleared RAM is acceptable.

Configuration
REQ-021 Macro IR_CAPTURE_EN defined: rising edge of ir_valid latches ir_code and sets ir_new; read of +4 clears ir_new; set and clear in same cycle -> ir_new=1.
REQ-022 IR_CAPTURE_EN undefined: +2..+4 read 0, no IR latch logic, ir_code/ir_valid unused.

Structure
REQ-023 Shared package SHALL hold MMIO offset constants, FSM state enum, ADDR_W/DATA_W defaults.
REQ-024 Clear counter and its done flag SHALL be sub-module ram_clear_seq.

Verification
REQ-025 Write 16'hBEEF to addr 5, read addr 5 -> ram_we 1 cycle, read returns 16'hBEEF after 2 cycles, cpu_stall high 1 cycle.
REQ-026 Write 16'h1234 to addr 110, read 110 -> tube_value=16'h1234, read returns 16'h1234 in 1 cycle, ram_we never asserted.
REQ-027 cpu_clr pulse with concurrent write to addr 7 -> write dropped, exactly 4096 ram_we cycles addr 0..4095 data 0, cpu_stall high 4096 cycles.
REQ-028 res low at clear cycle 100 -> IDLE, cpu_stall 0, ram_we 0 immediately (asynchronously).
REQ-029 IR_CAPTURE_EN: ir_code=32'hA55A00FF, ir_valid pulse -> reads 112=16'hA55A, 113=16'h00FF, 114=1 then 114=0.
REQ-030 btns=4'b1010, read 111 -> 16'h000A; write to 111 -> no state change.
